// File: rtl/clock_mon_scanner.sv
`default_nettype none
// ------------------------------------------------------------------------
// clock_mon_scanner: calibrates the clock monitor, then polls each clock and
// flags frequencies outside expected +/- (expected >> TOL_SHIFT).  Rev 1.0
// ------------------------------------------------------------------------
module clock_mon_scanner #(
   parameter int unsigned                NUM_CLOCKS    = 8,
   parameter logic [31:0]                REF_FREQ      = 32'd40000000,
   parameter logic [32*NUM_CLOCKS-1:0]   EXPECTED_FREQ = {NUM_CLOCKS{32'd0}},
   parameter int unsigned                TOL_SHIFT     = 6,
   parameter int unsigned                SETTLE_CYCLES = 2000000,
   parameter int unsigned                POLL_GAP      = 65536,
   parameter int unsigned                ACK_TIMEOUT   = 15,
   localparam int unsigned               AW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cal_i,
   output logic [AW-1:0]         mon_adr_o,
   output logic                  mon_en_o,
   output logic                  mon_wr_o,
   output logic [31:0]           mon_dat_o,
   input  logic [31:0]           mon_dat_i,
   input  logic                  mon_ack_i,
   output logic [31:0]           freq_o,
   output logic [AW-1:0]         freq_adr_o,
   output logic                  freq_valid_o,
   output logic [NUM_CLOCKS-1:0] freq_ok_o,
   output logic                  scan_valid_o,
   output logic                  scan_done_o,
   output logic                  alarm_o,
   output logic                  bus_err_o
);

   localparam int unsigned CMAX = (SETTLE_CYCLES > POLL_GAP) ? SETTLE_CYCLES : POLL_GAP;
   localparam int unsigned CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
   localparam int unsigned TW   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [CW-1:0] POLL_LAST   = CW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
   localparam logic [TW-1:0] TMO_LAST    = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   localparam logic [AW-1:0] ADR_LAST    = AW'(NUM_CLOCKS - 1);

   typedef enum logic [2:0] {
      ST_CAL    = 3'd0,
      ST_SETTLE = 3'd1,
      ST_GAP1   = 3'd2,
      ST_RD     = 3'd3,
      ST_CHK    = 3'd4,
      ST_NEXT   = 3'd5,
      ST_PAUSE  = 3'd6,
      ST_GAP0   = 3'd7
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic                  en_q, en_d;
   logic                  wr_q, wr_d;
   logic [31:0]           dat_q, dat_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [31:0]           freq_q, freq_d;
   logic [AW-1:0]         freq_adr_q, freq_adr_d;
   logic                  freq_valid_q, freq_valid_d;
   logic [NUM_CLOCKS-1:0] ok_q, ok_d;
   logic                  scan_valid_q, scan_valid_d;
   logic                  scan_done_q, scan_done_d;
   logic                  alarm_q, alarm_d;
   logic                  bus_err_q, bus_err_d;

   logic [31:0] exp_w;
   logic [32:0] tol_w, lo_w, hi_w;
   logic        in_tol_w, ack_w, tmo_w;

   // Window is computed in 33 bits; the high bound saturates at 2^32-1.
   always_comb begin
      exp_w = EXPECTED_FREQ[32*int'(addr_q) +: 32];
      tol_w = {1'b0, exp_w} >> TOL_SHIFT;
      lo_w  = {1'b0, exp_w} - tol_w;
      hi_w  = {1'b0, exp_w} + tol_w;
      if (hi_w[32]) begin
         hi_w = 33'h0_FFFF_FFFF;
      end
      in_tol_w = ({1'b0, mon_dat_i} >= lo_w) && ({1'b0, mon_dat_i} <= hi_w);
   end

   assign ack_w = en_q & mon_ack_i;
   assign tmo_w = en_q & ~mon_ack_i & (tmo_q == TMO_LAST);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      en_d         = en_q;
      wr_d         = wr_q;
      dat_d        = dat_q;
      tmo_d        = '0;
      cnt_d        = cnt_q;
      freq_d       = freq_q;
      freq_adr_d   = freq_adr_q;
      freq_valid_d = 1'b0;
      ok_d         = ok_q;
      scan_valid_d = scan_valid_q;
      scan_done_d  = 1'b0;
      bus_err_d    = bus_err_q;
      alarm_d      = scan_valid_q & ~(&ok_q);

      if (en_q && !ack_w && !tmo_w) begin
         tmo_d = tmo_q + 1'b1;
      end

      if (cal_i) begin
         state_d      = ST_GAP0;
         en_d         = 1'b0;
         addr_d       = '0;
         tmo_d        = '0;
         cnt_d        = '0;
         ok_d         = '0;
         scan_valid_d = 1'b0;
         bus_err_d    = 1'b0;
      end else begin
         case (state_q)
            // en_q is low here only straight out of reset; otherwise GAP0 issued it.
            ST_CAL: begin
               if (!en_q) begin
                  en_d  = 1'b1;
                  wr_d  = 1'b1;
                  dat_d = REF_FREQ;
               end else if (ack_w || tmo_w) begin
                  en_d      = 1'b0;
                  bus_err_d = bus_err_q | tmo_w;
                  cnt_d     = '0;
                  state_d   = (SETTLE_CYCLES == 0) ? ST_GAP1 : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_GAP1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_GAP1: begin
               en_d    = 1'b1;
               wr_d    = 1'b0;
               state_d = ST_RD;
            end
            ST_RD: begin
               if (ack_w) begin
                  en_d         = 1'b0;
                  freq_d       = mon_dat_i;
                  freq_adr_d   = addr_q;
                  freq_valid_d = 1'b1;
                  ok_d[addr_q] = in_tol_w;
                  state_d      = ST_CHK;
               end else if (tmo_w) begin
                  en_d         = 1'b0;
                  bus_err_d    = 1'b1;
                  ok_d[addr_q] = 1'b0;
                  state_d      = ST_NEXT;
               end
            end
            ST_CHK: begin
               state_d = ST_NEXT;
            end
            ST_NEXT: begin
               if (addr_q == ADR_LAST) begin
                  addr_d       = '0;
                  scan_done_d  = 1'b1;
                  scan_valid_d = 1'b1;
                  cnt_d        = '0;
                  state_d      = (POLL_GAP == 0) ? ST_GAP1 : ST_PAUSE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = ST_GAP1;
               end
            end
            ST_PAUSE: begin
               if (cnt_q == POLL_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_GAP1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_GAP0: begin
               en_d    = 1'b1;
               wr_d    = 1'b1;
               dat_d   = REF_FREQ;
               state_d = ST_CAL;
            end
            default: begin
               state_d = ST_GAP0;
               en_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_CAL;
         addr_q       <= '0;
         en_q         <= 1'b0;
         wr_q         <= 1'b0;
         dat_q        <= '0;
         tmo_q        <= '0;
         cnt_q        <= '0;
         freq_q       <= '0;
         freq_adr_q   <= '0;
         freq_valid_q <= 1'b0;
         ok_q         <= '0;
         scan_valid_q <= 1'b0;
         scan_done_q  <= 1'b0;
         alarm_q      <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         en_q         <= en_d;
         wr_q         <= wr_d;
         dat_q        <= dat_d;
         tmo_q        <= tmo_d;
         cnt_q        <= cnt_d;
         freq_q       <= freq_d;
         freq_adr_q   <= freq_adr_d;
         freq_valid_q <= freq_valid_d;
         ok_q         <= ok_d;
         scan_valid_q <= scan_valid_d;
         scan_done_q  <= scan_done_d;
         alarm_q      <= alarm_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign mon_adr_o    = addr_q;
   assign mon_en_o     = en_q;
   assign mon_wr_o     = wr_q;
   assign mon_dat_o    = dat_q;
   assign freq_o       = freq_q;
   assign freq_adr_o   = freq_adr_q;
   assign freq_valid_o = freq_valid_q;
   assign freq_ok_o    = ok_q;
   assign scan_valid_o = scan_valid_q;
   assign scan_done_o  = scan_done_q;
   assign alarm_o      = alarm_q;
   assign bus_err_o    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_mon_scanner.sv
`default_nettype none
// tb_clock_mon_scanner: scoreboard bench with a behavioural monitor responder
// that acks on the second cycle of en and logs every bus transaction.
module tb_clock_mon_scanner;
   localparam int          N   = 4;
   localparam logic [31:0] REF = 32'd40000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cal;
   logic [1:0]  mon_adr;
   logic        mon_en, mon_wr, mon_ack;
   logic [31:0] mon_wdat, mon_rdat;
   logic [31:0] freq;
   logic [1:0]  freq_adr;
   logic        freq_valid, scan_valid, scan_done, alarm, bus_err;
   logic [3:0]  freq_ok;

   always #5 clk = ~clk;

   clock_mon_scanner #(
      .NUM_CLOCKS    (N),
      .REF_FREQ      (REF),
      .EXPECTED_FREQ ({32'd64000000, 32'd0, 32'd250000000, 32'd125000000}),
      .TOL_SHIFT     (6),
      .SETTLE_CYCLES (100),
      .POLL_GAP      (20),
      .ACK_TIMEOUT   (15)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cal_i        (cal),
      .mon_adr_o    (mon_adr),
      .mon_en_o     (mon_en),
      .mon_wr_o     (mon_wr),
      .mon_dat_o    (mon_wdat),
      .mon_dat_i    (mon_rdat),
      .mon_ack_i    (mon_ack),
      .freq_o       (freq),
      .freq_adr_o   (freq_adr),
      .freq_valid_o (freq_valid),
      .freq_ok_o    (freq_ok),
      .scan_valid_o (scan_valid),
      .scan_done_o  (scan_done),
      .alarm_o      (alarm),
      .bus_err_o    (bus_err)
   );

   typedef struct { int adr; logic [31:0] val; } freq_t;
   typedef struct { logic [3:0] ok; logic alarm; logic be; } scan_t;
   typedef struct { logic wr; int adr; logic [31:0] dat; int gap; int len; bit acked; bit stable; } txn_t;

   freq_t exp_freq_q[$];
   scan_t exp_scan_q[$];
   txn_t  log_q[$];
   logic [31:0] rsp [N];
   int noack_adr = -1;
   int checks = 0;
   int errors = 0;
   int scans_seen = 0;

   // Per-scan read data, expected ok flags, alarm, bus_err and non-acking address.
   localparam logic [31:0] VEC [8][4] = '{
      '{32'd125009920, 32'd250003456, 32'd0, 32'd45000000},
      '{32'd125009920, 32'd250003456, 32'd0, 32'd63000000},
      '{32'd125009920, 32'd250003456, 32'd0, 32'd65000001},
      '{32'd125009920, 32'd250003456, 32'd0, 32'd65000000},
      '{32'd125009920, 32'd250003456, 32'd1, 32'd62999999},
      '{32'd125009920, 32'd250003456, 32'd0, 32'd64000000},
      '{32'd125000000, 32'd250000000, 32'd0, 32'd64000000},
      '{32'd126953125, 32'd246093750, 32'd0, 32'd64000000}
   };
   localparam logic [3:0] SOK [8] = '{4'b0111, 4'b1111, 4'b0111, 4'b1111, 4'b0011, 4'b1011, 4'b0000, 4'b1111};
   localparam logic       SAL [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic       SBE [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam int         SNA [8] = '{-1, -1, -1, -1, -1, 2, -1, -1};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load(input int s, input int nadr);
      noack_adr = SNA[s];
      for (int a = 0; a < N; a++) begin
         rsp[a] = VEC[s][a];
         if (a < nadr && a != SNA[s]) exp_freq_q.push_back('{a, VEC[s][a]});
      end
      if (nadr == N) exp_scan_q.push_back('{SOK[s], SAL[s], SBE[s]});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_en"}, {31'd0, mon_en}, 0);
      check({tag, "_wr"}, {31'd0, mon_wr}, 0);
      check({tag, "_adr"}, {30'd0, mon_adr}, 0);
      check({tag, "_wdat"}, mon_wdat, 0);
      check({tag, "_freq"}, freq, 0);
      check({tag, "_freq_ok"}, {28'd0, freq_ok}, 0);
      check({tag, "_flags"}, {26'd0, freq_adr, freq_valid, scan_valid, scan_done, alarm}, 0);
      check({tag, "_bus_err"}, {31'd0, bus_err}, 0);
   endtask

   task automatic wait_scans(input int target);
      int n = 0;
      while (scans_seen < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("scan_count", scans_seen, target);
   endtask

   task automatic wait_log(input int target);
      int n = 0;
      while (log_q.size() < target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("log_reached", (log_q.size() >= target) ? 1 : 0, 1);
   endtask

   task automatic bus_rules();
      bit good = 1'b1;
      foreach (log_q[i]) begin
         if (!log_q[i].stable) good = 1'b0;
         if (i > 0 && log_q[i].gap < 1) good = 1'b0;
      end
      check("bus_rules", {31'd0, good}, 1);
   endtask

   // Responder: ack registered from en, asserted on the second en cycle.
   initial begin
      txn_t cur;
      int en_cnt = 0;
      int low_cnt = 0;
      mon_ack  = 1'b0;
      mon_rdat = '0;
      cur = '{1'b0, 0, 32'd0, 0, 0, 1'b0, 1'b1};
      forever begin
         @(posedge clk);
         #1;
         if (mon_en === 1'b1) begin
            if (en_cnt == 0) begin
               cur = '{mon_wr, int'(mon_adr), mon_wdat, low_cnt, 0, 1'b0, 1'b1};
            end else if (mon_wr !== cur.wr || int'(mon_adr) != cur.adr || mon_wdat !== cur.dat) begin
               cur.stable = 1'b0;
            end
            en_cnt++;
            if (mon_ack) begin
               mon_ack = 1'b0;
            end else if (en_cnt == 2 && !(!mon_wr && int'(mon_adr) == noack_adr)) begin
               mon_ack   = 1'b1;
               mon_rdat  = rsp[mon_adr];
               cur.acked = 1'b1;
            end
         end else begin
            mon_ack = 1'b0;
            if (en_cnt != 0) begin
               cur.len = en_cnt;
               log_q.push_back(cur);
               low_cnt = 1;
            end else begin
               low_cnt++;
            end
            en_cnt = 0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a result.
   bit   alarm_pend = 1'b0;
   logic alarm_exp  = 1'b0;
   initial begin
      freq_t e;
      scan_t s;
      forever begin
         @(negedge clk);
         if (alarm_pend) begin
            check("alarm", {31'd0, alarm}, {31'd0, alarm_exp});
            alarm_pend = 1'b0;
         end
         if (freq_valid === 1'b1) begin
            if (exp_freq_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_freq_valid: got adr %0d freq %0d, expected no strobe", freq_adr, freq);
            end else begin
               e = exp_freq_q.pop_front();
               check("freq_adr", {30'd0, freq_adr}, e.adr);
               check("freq", freq, e.val);
            end
         end
         if (scan_done === 1'b1) begin
            scans_seen++;
            if (exp_scan_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_scan_done: got pulse, expected none");
            end else begin
               s = exp_scan_q.pop_front();
               check("freq_ok", {28'd0, freq_ok}, {28'd0, s.ok});
               check("bus_err", {31'd0, bus_err}, {31'd0, s.be});
               check("scan_valid", {31'd0, scan_valid}, 1);
               alarm_pend = 1'b1;
               alarm_exp  = s.alarm;
            end
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      cal = 1'b0;
      load(0, N);
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      wait_scans(1);
      check("scan0_log_size", log_q.size(), 5);
      if (log_q.size() >= 5) begin
         check("cal_wr", {31'd0, log_q[0].wr}, 1);
         check("cal_adr", log_q[0].adr, 0);
         check("cal_dat", log_q[0].dat, REF);
         check("settle_gap", log_q[1].gap, 101);
         for (int i = 1; i < 5; i++) begin
            check("scan_order_adr", log_q[i].adr, i - 1);
            check("scan_rd", {31'd0, log_q[i].wr}, 0);
         end
      end
      bus_rules();
      log_q.delete();

      for (int s = 1; s <= 5; s++) begin
         load(s, N);
         wait_scans(s + 1);
         bus_rules();
         if (s == 5) begin
            check("to_log_size", log_q.size(), 4);
            if (log_q.size() == 4) begin
               check("to_adr", log_q[2].adr, 2);
               check("to_len", log_q[2].len, 15);
               check("to_acked", {31'd0, log_q[2].acked}, 0);
               check("after_to_adr", log_q[3].adr, 3);
            end
         end
         log_q.delete();
      end

      // Recalibrate while the adr 1 read is in flight.
      load(6, 1);
      n = 0;
      while (!(mon_en === 1'b1 && mon_adr == 2'd1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("en_at_adr1_seen", (n < 500) ? 1 : 0, 1);
      cal = 1'b1;
      @(negedge clk);
      cal = 1'b0;
      check("en_after_cal", {31'd0, mon_en}, 0);
      check("bus_err_after_cal", {31'd0, bus_err}, 0);
      check("scan_valid_after_cal", {31'd0, scan_valid}, 0);
      load(7, N);
      wait_log(4);
      check("recal_scan_valid", {31'd0, scan_valid}, 0);
      check("recal_bus_err", {31'd0, bus_err}, 0);
      wait_scans(7);
      bus_rules();
      if (log_q.size() >= 4) begin
         check("abandoned_acked", {31'd0, log_q[1].acked}, 0);
         check("abandoned_len", log_q[1].len, 1);
         check("recal_wr", {31'd0, log_q[2].wr}, 1);
         check("recal_dat", log_q[2].dat, REF);
         check("recal_settle_gap", log_q[3].gap, 101);
      end

      // Asynchronous reset in the middle of PAUSE.
      repeat (5) @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      log_q.delete();
      wait_log(1);
      if (log_q.size() >= 1) begin
         check("post_reset_wr", {31'd0, log_q[0].wr}, 1);
         check("post_reset_adr", log_q[0].adr, 0);
         check("post_reset_dat", log_q[0].dat, REF);
      end
      check("freq_queue_drained", exp_freq_q.size(), 0);
      check("scan_queue_drained", exp_scan_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clock_mon_scanner.md
Name: clock_mon_scanner

Overview:
- Bus initiator for the simple register-style clock monitor interface (adr/en/wr/dat/ack).
- After reset, writes the reference-clock calibration value and waits for the monitor to settle.
- Then continuously reads each monitored clock's frequency and compares it against a per-clock expected value with a power-of-2 tolerance.
- Produces per-clock OK flags and a summary alarm in the clk_i domain for the TURFIO housekeeping and status logic.

Parameters:
NUM_CLOCKS, 8, number of monitor addresses scanned (0..NUM_CLOCKS-1)
REF_FREQ, 40000000, calibration value written to the monitor, in Hz of clk_i
EXPECTED_FREQ, {NUM_CLOCKS{32'd0}}, packed 32-bit expected Hz per clock; entry i is [32*i +: 32]
TOL_SHIFT, 6, tolerance = expected >> TOL_SHIFT (default ~1.56%)
SETTLE_CYCLES, 2000000, clk_i cycles waited after the calibration write
POLL_GAP, 65536, idle clk_i cycles between full scans
ACK_TIMEOUT, 15, cycles without ack before a transaction is abandoned

Ports:
clk_i  in  1  system clock; must be the same clock that drives the monitor
rst_i  in  1  asynchronous active-high reset
cal_i  in  1  single-cycle pulse; restarts from the calibration write
mon_adr_o  out  $clog2(NUM_CLOCKS)  monitor address
mon_en_o  out  1  transaction enable
mon_wr_o  out  1  1=write, 0=read
mon_dat_o  out  32  write data
mon_dat_i  in  32  read data
mon_ack_i  in  1  transaction acknowledge
freq_o  out  32  last frequency read, in Hz
freq_adr_o  out  $clog2(NUM_CLOCKS)  address of freq_o
freq_valid_o  out  1  1-cycle strobe when freq_o/freq_adr_o update
freq_ok_o  out  NUM_CLOCKS  per-clock in-tolerance flags
scan_valid_o  out  1  set after the first complete scan following a calibration
scan_done_o  out  1  1-cycle pulse at the end of each full scan
alarm_o  out  1  scan_valid_o & ~&freq_ok_o
bus_err_o  out  1  sticky; set on any ack timeout, cleared by reset or cal_i

Behaviour:
- Reset values: all outputs 0, mon_adr_o=0, FSM in CAL.
- Reset is asynchronous assert; release is synchronous to clk_i.
- Bus handshake:
  - mon_en_o is registered and held until the cycle mon_ack_i=1 is sampled, or until timeout.
  - mon_en_o, mon_adr_o, mon_wr_o and mon_dat_o are stable while mon_en_o=1.
  - After every transaction mon_en_o is low for at least 1 cycle, because the responder's ack is registered from en.
  - Back-to-back en would ack immediately with stale data and is forbidden.
  - Read data is captured on the cycle mon_ack_i=1.
- FSM states:
  - CAL: drive a write: mon_wr_o=1, mon_dat_o=REF_FREQ, mon_adr_o=0. On ack or timeout go to SETTLE. Clear scan_valid_o, freq_ok_o and bus_err_o on entry.
  - SETTLE: count SETTLE_CYCLES, then go to GAP1 with addr=0.
  - RD: drive a read at addr. On ack go to CHK; on timeout set bus_err_o, clear freq_ok_o[addr] and go to NEXT.
  - CHK (1 cycle):
    - freq_o=mon_dat_i, freq_adr_o=addr, pulse freq_valid_o.
    - freq_ok_o[addr] = (mon_dat_i >= exp-tol) && (mon_dat_i <= exp+tol).
    - Compute in 33 bits: the low bound saturates at 0 and the high bound at 2^32-1.
    - exp=0 means the clock is expected stopped: ok iff mon_dat_i==0.
  - NEXT: if addr==NUM_CLOCKS-1, then addr=0, pulse scan_done_o, set scan_valid_o, go to PAUSE. Otherwise addr+1 and go to GAP1.
  - GAP1: one idle cycle, then go to RD.
  - PAUSE: count POLL_GAP, then go to GAP1.
- Timeout: a counter runs while mon_en_o=1. At ACK_TIMEOUT cycles without ack, drop en; treat as above.
- cal_i:
  - Has priority in every state. The next cycle, drop mon_en_o (abandon any in-flight transaction, no capture) and enter GAP0→CAL.
  - GAP0 is one idle cycle guaranteeing en-low separation.
  - cal_i asserted while already in CAL restarts CAL after the gap.
- Simultaneous ack and timeout on the same cycle: ack wins.
- Counters are sized with $clog2(max+1); SETTLE_CYCLES=0 and POLL_GAP=0 mean a direct transition.
- alarm_o is registered from scan_valid_o and freq_ok_o (1-cycle latency).

Test Plan:
- Calibration write (NUM_CLOCKS=4, SETTLE_CYCLES=100, responder acks 2 cycles after en): after reset, one write with dat=40000000 and adr=0; en low for 100+1 cycles; then reads at adr 0,1,2,3 with ≥1 idle cycle between each.
- Tolerance check (EXPECTED={125e6,250e6,0,40e6}):
  - Read values 125009920, 250003456, 0 and 45000000 → freq_ok_o=4'b0111, scan_done_o pulses once, alarm_o=1 one cycle later.
  - Changing 45000000 to 40009728 on the next scan → alarm_o=0.
- Boundary: expected 64000000 with TOL_SHIFT=6 gives tolerance 1000000. Values 63000000 and 65000000 → ok; 62999999 and 65000001 → not ok.
- Timeout: responder never acks at adr 2 → en drops after 15 cycles, bus_err_o=1, freq_ok_o[2]=0, scan continues at adr 3.
- cal_i mid-read (while en=1 at adr 1):
  - en low the next cycle, no freq_valid_o strobe.
  - Then a calibration write; scan_valid_o=0 and bus_err_o=0 until the next full scan completes.
- Async reset asserted mid-PAUSE: all outputs 0 immediately without a clock edge; after release, a calibration write occurs again.
